spi_ram_arbiter: RTL and testbench
==================================

# spi_ram_arbiter

Two-requester round-robin controller that shares one single-port SPI RAM (10-bit command/data `din` bus, `rx_valid` strobe, `dout`/`tx_valid` return) between requester 0 (SPI slave side) and requester 1 (host/scrub side). Each requester presents a simple read/write request. The controller sequences the required RAM opcode cycles (00 = write address, 01 = write data, 10 = read address, 11 = read fetch), skips redundant address phases, and returns read data with a registered acknowledge.

## Interface
- `MEM_WIDTH`, default 8: RAM data width.
- `ADDR_SIZE`, default 8: RAM address width; must be no greater than `MEM_WIDTH`.
- `TIMEOUT`, default 4: maximum cycles spent in `RD_WAIT` before an error completion; minimum 1.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: request, held with fields stable until the matching `ack`.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in `ADDR_SIZE`: RAM address.
- `wdata0`, `wdata1` in `MEM_WIDTH`: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse, registered.
- `rdata0`, `rdata1` out `MEM_WIDTH`: read data, valid while `ack` is high; holds its value otherwise.
- `err0`, `err1` out 1: read timed out; valid with `ack`.
- `ram_din` out `MEM_WIDTH+2`: `{opcode[1:0], payload}`. Address payloads are zero-extended.
- `ram_rx_valid` out 1: command strobe to the RAM.
- `ram_dout` in `MEM_WIDTH`: RAM read data.
- `ram_tx_valid` in 1: RAM read-data valid.

## Operation
- FSM states: `IDLE`, `WR_ADDR`, `WR_DATA`, `RD_ADDR`, `RD_CMD`, `RD_WAIT`, `DONE`. Reset state is `IDLE`.
- **`IDLE` arbitration:**
  - If only one requester is asserting `req`, it wins.
  - If both assert `req`, the requester not granted last time wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - On grant: latch owner, `we`, addr and wdata; update `last_grant`.
- **Write path:**
  - If the write-address cache is valid and equals addr, go to `WR_DATA`; otherwise go to `WR_ADDR`.
  - `WR_ADDR`: `ram_din={00,addr}`, `ram_rx_valid=1`. Load the write cache (mark valid). Go to `WR_DATA`.
  - `WR_DATA`: `ram_din={01,wdata}`, `ram_rx_valid=1`. Go to `DONE`.
- **Read path:**
  - If the read-address cache is valid and equals addr, go to `RD_CMD`; otherwise go to `RD_ADDR`.
  - `RD_ADDR`: `ram_din={10,addr}`, `ram_rx_valid=1`. Load the read cache. Go to `RD_CMD`.
  - `RD_CMD`: `ram_din={11,0}`, `ram_rx_valid=0`. Clear the timeout counter. Go to `RD_WAIT`.
  - `RD_WAIT`: `ram_din=0`, `ram_rx_valid=0`.
    - On `ram_tx_valid=1`: capture `ram_dout` into the owner's rdata, clear err, go to `DONE`.
    - Otherwise increment the counter. When the counter reaches `TIMEOUT`: set err, set owner's rdata to 0, invalidate both caches, go to `DONE`.
- **`DONE`:** owner's ack is 1 (and err as determined). Go to `IDLE`. New requests are not sampled in `DONE`.
- **Outside the states above:** `ram_din=0` and `ram_rx_valid=0`. Opcode 11 is driven only in `RD_CMD`.
- `ram_tx_valid` is ignored outside `RD_WAIT`.
- **Reset values:** `ack0`, `ack1`, `err0`, `err1`, `ram_rx_valid` are 0; `ram_din`, `rdata0`, `rdata1` are 0; both caches invalid.
- **Reset mid-operation:** abort immediately, no ack issued, caches invalid. The requester must re-present its request after reset.
- **Requester rules:**
  - A requester may deassert `req` only in the cycle after its ack.
  - A `req` dropped before ack is a protocol violation; behaviour is undefined, and the bench asserts it never happens.

## Timing
- Request sampled in `IDLE` at cycle T:
  - Write, cache miss: ack at T+3.
  - Write, cache hit: ack at T+2.
  - Read, cache miss: RAM `tx_valid` expected at T+3, ack/rdata at T+4.
  - Read, cache hit: ack at T+3.
- Minimum spacing between successive grants: one `IDLE` cycle after each `DONE`.
  - Back-to-back cache-miss writes from one requester: one grant per 4 cycles.
  - Alternating requesters: strict alternation under continuous contention.
- Timeout completion: ack at `RD_CMD` cycle + `TIMEOUT` + 2.

## Test plan
- Reset, then `req0` write addr=0x12 data=0xA5 -> `ram_din` 0x012, then 0x1A5, `rx_valid` high for both cycles; `ack0` at T+3; `ack1` stays 0.
- `req1` read addr=0x12 after that write -> `ram_din` 0x212, then 0x300; `rdata1`=0xA5 with `ack1` at T+4, `err1`=0.
- Second write to 0x12 data=0x3C from `req0`, then read 0x12 from `req1` -> no 00/10 address phases (cache hits); acks at T+2 and T+3; `rdata1`=0x3C.
- `req0` and `req1` raised in the same cycle continuously for 4 transactions -> grants in order 0,1,0,1; no ack overlap; each ack exactly one cycle wide.
- RAM model withholds `tx_valid` on a read with `TIMEOUT`=4 -> ack with err=1 and rdata=0 at `RD_CMD`+6. The next read to the same address re-issues its 10 address phase.
- Assert `rst_n`=0 while the FSM is in `WR_DATA` -> outputs are immediately 0 with no ack. After release, an identical write issues a full 00/01 sequence.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter
//   Round-robin controller that lets two requesters share one single-port
//   SPI RAM. Each granted request is turned into the RAM opcode sequence
//   (00 write address, 01 write data, 10 read address, 11 read fetch).
//   An address phase is skipped when the RAM already holds that address.
//   Completion is a registered one-cycle ack, with read data and a
//   timeout error flag.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   req0/1               : request, held with stable fields until ack
//   we0/1                : 1 = write, 0 = read
//   addr0/1, wdata0/1    : request address / write data
//   ack0/1               : one-cycle completion pulse (registered)
//   rdata0/1             : read data, valid with ack, held otherwise
//   err0/1               : read timed out, valid with ack
//   ram_din              : {opcode[1:0], payload} command word to the RAM
//   ram_rx_valid         : command strobe to the RAM
//   ram_dout             : RAM read data
//   ram_tx_valid         : RAM read data valid (only looked at in RD_WAIT)
module spi_ram_arbiter #(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [MEM_WIDTH-1:0] wdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [MEM_WIDTH-1:0] wdata1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [MEM_WIDTH-1:0] rdata0,
    output logic [MEM_WIDTH-1:0] rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic [MEM_WIDTH+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, DONE
    } state_t;

    state_t                 state, state_nxt;

    // Latched request of the current owner
    logic                   owner;
    logic                   we_q;
    logic [ADDR_SIZE-1:0]   addr_q;
    logic [MEM_WIDTH-1:0]   wdata_q;
    logic                   last_grant;

    // Address caches: what the RAM's write / read address registers hold
    logic                   wc_vld, rc_vld;
    logic [ADDR_SIZE-1:0]   wc_addr, rc_addr;

    logic [CW-1:0]          cnt;

    // Control strobes from the next-state logic
    logic                   grant, grant_id;
    logic                   wc_load, rc_load;
    logic                   cnt_clr, cnt_inc;
    logic                   rd_ok, rd_to;

    // Selected requester fields during arbitration
    logic                   sel_we;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [MEM_WIDTH-1:0]   addr_ext;

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_SIZE-1:0] = addr_q;
    end

    // Tie goes to the requester not served last time
    always_comb begin
        grant_id = 1'b0;
        if (req0 && req1) grant_id = ~last_grant;
        else if (req1)    grant_id = 1'b1;
        sel_we   = grant_id ? we1   : we0;
        sel_addr = grant_id ? addr1 : addr0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        grant        = 1'b0;
        wc_load      = 1'b0;
        rc_load      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        rd_ok        = 1'b0;
        rd_to        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant = 1'b1;
                    if (sel_we)
                        state_nxt = (wc_vld && wc_addr == sel_addr) ? WR_DATA : WR_ADDR;
                    else
                        state_nxt = (rc_vld && rc_addr == sel_addr) ? RD_CMD : RD_ADDR;
                end
            end
            WR_ADDR: begin
                ram_din      = {2'b00, addr_ext};
                ram_rx_valid = 1'b1;
                wc_load      = 1'b1;
                state_nxt    = WR_DATA;
            end
            WR_DATA: begin
                ram_din      = {2'b01, wdata_q};
                ram_rx_valid = 1'b1;
                state_nxt    = DONE;
            end
            RD_ADDR: begin
                ram_din      = {2'b10, addr_ext};
                ram_rx_valid = 1'b1;
                rc_load      = 1'b1;
                state_nxt    = RD_CMD;
            end
            RD_CMD: begin
                // Fetch opcode is presented without a strobe
                ram_din   = {2'b11, {MEM_WIDTH{1'b0}}};
                cnt_clr   = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (ram_tx_valid) begin
                    rd_ok     = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CW'(TIMEOUT)) begin
                    rd_to     = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_grant <= 1'b1;
        end else if (grant) begin
            owner      <= grant_id;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= grant_id ? wdata1 : wdata0;
            last_grant <= grant_id;
        end
    end

    // Address caches; a timeout leaves the RAM state unknown, so drop both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc_vld  <= 1'b0;
            wc_addr <= '0;
            rc_vld  <= 1'b0;
            rc_addr <= '0;
        end else if (rd_to) begin
            wc_vld <= 1'b0;
            rc_vld <= 1'b0;
        end else begin
            if (wc_load) begin
                wc_vld  <= 1'b1;
                wc_addr <= addr_q;
            end
            if (rc_load) begin
                rc_vld  <= 1'b1;
                rc_addr <= addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_inc) cnt <= cnt + 1'b1;
    end

    // Completion outputs: registered so ack/err/rdata line up in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= (state_nxt == DONE) && (state != DONE) && !owner;
            ack1 <= (state_nxt == DONE) && (state != DONE) &&  owner;
            err0 <= rd_to && !owner;
            err1 <= rd_to &&  owner;
            if (rd_ok) begin
                if (owner) rdata1 <= ram_dout;
                else       rdata0 <= ram_dout;
            end else if (rd_to) begin
                if (owner) rdata1 <= '0;
                else       rdata0 <= '0;
            end
        end
    end

    // we_q only steers the path choice at grant time; kept for debug visibility
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;
    logic       withhold;

    int n_chk  = 0;
    int n_fail = 0;

    spi_ram_arbiter #(.MEM_WIDTH(8), .ADDR_SIZE(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    always #5 clk = ~clk;

    // Simple SPI RAM: answers a fetch one cycle after it is presented
    logic [7:0] mem [0:255];
    logic [7:0] m_wa = 8'h00, m_ra = 8'h00;
    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00:   m_wa <= ram_din[7:0];
                2'b01:   mem[m_wa] <= ram_din[7:0];
                2'b10:   m_ra <= ram_din[7:0];
                default: ;
            endcase
        end
        if (ram_din[9:8] == 2'b11 && !withhold) begin
            ram_tx_valid <= 1'b1;
            ram_dout     <= mem[m_ra];
        end else begin
            ram_tx_valid <= 1'b0;
        end
    end

    // Requester protocol: req may only fall in the cycle after its ack
    logic p_req0 = 1'b0, p_req1 = 1'b0, p_ack0 = 1'b0, p_ack1 = 1'b0, p_rst = 1'b0;
    always @(negedge clk) begin
        if (rst_n && p_rst) begin
            if (p_req0 && !req0) begin
                n_chk++;
                assert (p_ack0 === 1'b1) else begin
                    n_fail++;
                    $error("FAIL req0_drop: req0 fell, prior ack0=%0b required 1", p_ack0);
                end
            end
            if (p_req1 && !req1) begin
                n_chk++;
                assert (p_ack1 === 1'b1) else begin
                    n_fail++;
                    $error("FAIL req1_drop: req1 fell, prior ack1=%0b required 1", p_ack1);
                end
            end
        end
        p_req0 <= req0;
        p_req1 <= req1;
        p_ack0 <= ack0;
        p_ack1 <= ack1;
        p_rst  <= rst_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; withhold = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_ack0", 32'(ack0), 32'h0);
        chk("rst_ack1", 32'(ack1), 32'h0);
        chk("rst_err0", 32'(err0), 32'h0);
        chk("rst_err1", 32'(err1), 32'h0);
        chk("rst_rxv",  32'(ram_rx_valid), 32'h0);
        chk("rst_din",  32'(ram_din), 32'h0);
        chk("rst_rd0",  32'(rdata0), 32'h0);
        chk("rst_rd1",  32'(rdata1), 32'h0);
        rst_n = 1'b1;
        tick();

        // Write miss from requester 0: 0x12 <- 0xA5
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h12; wdata0 = 8'hA5;
        tick();
        chk("w1_din_a", 32'(ram_din), 32'h012);
        chk("w1_rxv_a", 32'(ram_rx_valid), 32'h1);
        chk("w1_ack0_a", 32'(ack0), 32'h0);
        tick();
        chk("w1_din_d", 32'(ram_din), 32'h1A5);
        chk("w1_rxv_d", 32'(ram_rx_valid), 32'h1);
        tick();
        chk("w1_ack0", 32'(ack0), 32'h1);
        chk("w1_ack1", 32'(ack1), 32'h0);
        chk("w1_err0", 32'(err0), 32'h0);
        tick();
        chk("w1_ack0_pulse", 32'(ack0), 32'h0);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h12;

        // Read miss from requester 1
        tick();
        chk("r1_din_a", 32'(ram_din), 32'h212);
        chk("r1_rxv_a", 32'(ram_rx_valid), 32'h1);
        tick();
        chk("r1_din_c", 32'(ram_din), 32'h300);
        chk("r1_rxv_c", 32'(ram_rx_valid), 32'h0);
        tick();
        chk("r1_ack1_w", 32'(ack1), 32'h0);
        chk("r1_din_w", 32'(ram_din), 32'h0);
        tick();
        chk("r1_ack1", 32'(ack1), 32'h1);
        chk("r1_rdata1", 32'(rdata1), 32'hA5);
        chk("r1_err1", 32'(err1), 32'h0);
        chk("r1_ack0", 32'(ack0), 32'h0);
        tick();
        chk("r1_hold_ack", 32'(ack1), 32'h0);
        chk("r1_hold_rd", 32'(rdata1), 32'hA5);
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h12; wdata0 = 8'h3C;

        // Write hit: data phase only
        tick();
        chk("w2_din_d", 32'(ram_din), 32'h13C);
        chk("w2_rxv_d", 32'(ram_rx_valid), 32'h1);
        tick();
        chk("w2_ack0", 32'(ack0), 32'h1);
        tick();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h12;

        // Read hit: straight to fetch
        tick();
        chk("r2_din_c", 32'(ram_din), 32'h300);
        chk("r2_rxv_c", 32'(ram_rx_valid), 32'h0);
        tick();
        chk("r2_din_w", 32'(ram_din), 32'h0);
        chk("r2_ack1_w", 32'(ack1), 32'h0);
        tick();
        chk("r2_ack1", 32'(ack1), 32'h1);
        chk("r2_rdata1", 32'(rdata1), 32'h3C);
        chk("r2_err1", 32'(err1), 32'h0);
        tick();

        // Continuous contention: last grant was 1, so order is 0,1,0,1
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h11;
        we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'h22;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("rr_ack0_%0d", k), 32'(ack0), 32'(k == 3 || k == 11));
            chk($sformatf("rr_ack1_%0d", k), 32'(ack1), 32'(k == 7 || k == 15));
            if (k == 1) chk("rr_din_1", 32'(ram_din), 32'h020);
            if (k == 5) chk("rr_din_5", 32'(ram_din), 32'h021);
            if (k == 9) chk("rr_din_9", 32'(ram_din), 32'h020);
            if (k == 12) req0 = 1'b0;
            if (k == 16) req1 = 1'b0;
        end

        // Read miss from requester 0 of 0x21 (holds 0x22)
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h21;
        tick();
        chk("r3_din_a", 32'(ram_din), 32'h221);
        tick();
        tick();
        tick();
        chk("r3_ack0", 32'(ack0), 32'h1);
        chk("r3_rdata0", 32'(rdata0), 32'h22);
        chk("r3_err0", 32'(err0), 32'h0);
        tick();

        // Same read (cache hit) with the RAM silent: timeout at RD_CMD+6
        withhold = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("to_ack0_%0d", k), 32'(ack0), 32'(k == 7));
            chk($sformatf("to_err0_%0d", k), 32'(err0), 32'(k == 7));
            if (k == 1) chk("to_din_c", 32'(ram_din), 32'h300);
            if (k == 2) chk("to_rxv_w", 32'(ram_rx_valid), 32'h0);
            if (k == 7) chk("to_rdata0", 32'(rdata0), 32'h0);
        end
        tick();
        withhold = 1'b0;

        // Caches were dropped: the retry re-issues its address phase
        tick();
        chk("r4_din_a", 32'(ram_din), 32'h221);
        chk("r4_rxv_a", 32'(ram_rx_valid), 32'h1);
        tick();
        tick();
        tick();
        chk("r4_ack0", 32'(ack0), 32'h1);
        chk("r4_rdata0", 32'(rdata0), 32'h22);
        chk("r4_err0", 32'(err0), 32'h0);
        tick();
        we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h55;

        // Reset while in WR_DATA
        tick();
        chk("w5_din_a", 32'(ram_din), 32'h030);
        tick();
        chk("w5_din_d", 32'(ram_din), 32'h155);
        rst_n = 1'b0;
        #1;
        chk("mr_din", 32'(ram_din), 32'h0);
        chk("mr_rxv", 32'(ram_rx_valid), 32'h0);
        chk("mr_ack0", 32'(ack0), 32'h0);
        chk("mr_rdata0", 32'(rdata0), 32'h0);
        req0 = 1'b0;
        tick();
        chk("mr_ack0_edge", 32'(ack0), 32'h0);
        rst_n = 1'b1;
        tick();
        req0 = 1'b1;
        tick();
        chk("w6_din_a", 32'(ram_din), 32'h030);
        chk("w6_rxv_a", 32'(ram_rx_valid), 32'h1);
        tick();
        chk("w6_din_d", 32'(ram_din), 32'h155);
        tick();
        chk("w6_ack0", 32'(ack0), 32'h1);
        chk("w6_ack1", 32'(ack1), 32'h0);
        tick();
        req0 = 1'b0;
        chk("w6_ack0_pulse", 32'(ack0), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
